// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks in-flight GPR writers after D and
// produces the decode stall plus the rs/rt forwarding selects.
module hs_src_match #(
    parameter int DEPTH = 3,
    parameter int RAW   = 5,
    parameter int TW    = 2,
    parameter int FW    = 2
) (
    input  logic                       bubble_d,
    input  logic [RAW-1:0]             src,
    input  logic [TW-1:0]              tuse,
    input  logic [DEPTH-1:0]           ent_vld,
    input  logic [DEPTH-1:0][RAW-1:0]  ent_rd,
    input  logic [DEPTH-1:0][TW-1:0]   ent_tnew,
    output logic                       hazard,
    output logic [FW-1:0]              fwd
);
    logic          used;
    logic          hit;
    logic [TW-1:0] hit_tnew;
    logic [FW-1:0] hit_sel;

    always_comb begin
        used     = (src != '0) && (tuse != '1) && !bubble_d;
        hit      = 1'b0;
        hit_tnew = '0;
        hit_sel  = '0;
        // Scan oldest to youngest so the youngest matching producer wins.
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (ent_vld[k] && (ent_rd[k] == src)) begin
                hit      = 1'b1;
                hit_tnew = ent_tnew[k];
                hit_sel  = FW'(k + 1);
            end
        end
        hazard = used && hit && (hit_tnew > tuse);
        fwd    = (used && hit && (hit_tnew == '0)) ? hit_sel : '0;
    end
endmodule

module hazard_scoreboard #(
    parameter  int DEPTH     = 3,
    parameter  int RAW       = 5,
    parameter  int TW        = 2,
    parameter  int MD_CYCLES = 4,
    localparam int FW        = $clog2(DEPTH + 1),
    localparam int MDW       = $clog2(MD_CYCLES + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           bubble_d,
    input  logic [RAW-1:0] rs_d,
    input  logic [RAW-1:0] rt_d,
    input  logic [TW-1:0]  tuse_rs,
    input  logic [TW-1:0]  tuse_rt,
    input  logic           wr_en_d,
    input  logic [RAW-1:0] wr_reg_d,
    input  logic [TW-1:0]  tnew_d,
    input  logic           md_start_d,
    input  logic           md_use_d,
    output logic           stall,
    output logic [FW-1:0]  fwd_rs,
    output logic [FW-1:0]  fwd_rt,
    output logic           md_busy
);
    logic [DEPTH-1:0]          ent_vld;
    logic [DEPTH-1:0][RAW-1:0] ent_rd;
    logic [DEPTH-1:0][TW-1:0]  ent_tnew;
    logic [MDW-1:0]            md_cnt;

    logic [1:0][RAW-1:0] src;
    logic [1:0][TW-1:0]  tuse;
    logic [1:0]          src_haz;
    logic [1:0][FW-1:0]  src_fwd;
    logic                md_stall;
    logic                issue;
    logic                ld_vld;

    assign src  = {rt_d, rs_d};
    assign tuse = {tuse_rt, tuse_rs};

    for (genvar g = 0; g < 2; g++) begin : g_src
        hs_src_match #(.DEPTH(DEPTH), .RAW(RAW), .TW(TW), .FW(FW)) u_match (
            .bubble_d (bubble_d),
            .src      (src[g]),
            .tuse     (tuse[g]),
            .ent_vld  (ent_vld),
            .ent_rd   (ent_rd),
            .ent_tnew (ent_tnew),
            .hazard   (src_haz[g]),
            .fwd      (src_fwd[g])
        );
    end

    assign fwd_rs   = src_fwd[0];
    assign fwd_rt   = src_fwd[1];
    assign md_busy  = (md_cnt != '0);
    assign md_stall = md_use_d && md_busy && !bubble_d;
    assign stall    = !bubble_d && ((|src_haz) || md_stall);
    assign issue    = !bubble_d && !stall;
    // Writes to $0 are architecturally dropped, so they never occupy an entry.
    assign ld_vld   = wr_en_d && issue && (wr_reg_d != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_vld  <= '0;
            ent_rd   <= '0;
            ent_tnew <= '0;
            md_cnt   <= '0;
        end else begin
            ent_vld[0]  <= ld_vld;
            ent_rd[0]   <= ld_vld ? wr_reg_d : '0;
            ent_tnew[0] <= ld_vld ? tnew_d : '0;
            for (int k = 1; k < DEPTH; k++) begin
                ent_vld[k]  <= ent_vld[k-1];
                ent_rd[k]   <= ent_rd[k-1];
                ent_tnew[k] <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TW'(1);
            end
            if (md_start_d && issue)
                md_cnt <= MDW'(MD_CYCLES);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - MDW'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic,
// all checked against a producer-list reference model.
module tb_hazard_scoreboard;
    localparam int DEPTH     = 3;
    localparam int RAW       = 5;
    localparam int TW        = 2;
    localparam int MD_CYCLES = 4;
    localparam int FW        = $clog2(DEPTH + 1);
    localparam int TUSE_NONE = (1 << TW) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           bubble_d;
    logic [RAW-1:0] rs_d, rt_d, wr_reg_d;
    logic [TW-1:0]  tuse_rs, tuse_rt, tnew_d;
    logic           wr_en_d, md_start_d, md_use_d;
    logic           stall, md_busy;
    logic [FW-1:0]  fwd_rs, fwd_rt;

    hazard_scoreboard #(.DEPTH(DEPTH), .RAW(RAW), .TW(TW), .MD_CYCLES(MD_CYCLES)) dut (
        .clk(clk), .reset(reset), .bubble_d(bubble_d), .rs_d(rs_d), .rt_d(rt_d),
        .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .wr_en_d(wr_en_d), .wr_reg_d(wr_reg_d),
        .tnew_d(tnew_d), .md_start_d(md_start_d), .md_use_d(md_use_d),
        .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: list of issued GPR writers, each stamped with the edge it entered E.
    typedef struct {
        int e;
        int rd;
        int tn;
    } prod_t;
    prod_t prods[$];
    int    cyc = 0;
    int    md_e = -1000;
    bit    e_stall, e_busy;
    int    e_fwd_rs, e_fwd_rt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void src_model(input int s, input int tu, output bit hz, output int fw);
        int best, tn, age;
        hz = 1'b0; fw = 0; best = -1; tn = 0;
        if (s == 0 || tu == TUSE_NONE || bubble_d) return;
        foreach (prods[i])
            if ((cyc - prods[i].e) < DEPTH && prods[i].rd == s && prods[i].e > best) begin
                best = prods[i].e;
                tn   = prods[i].tn;
            end
        if (best < 0) return;
        age = cyc - best;
        tn  = (tn > age) ? tn - age : 0;
        hz  = tn > tu;
        fw  = (tn == 0) ? age + 1 : 0;
    endfunction

    task automatic model_eval();
        bit hr, ht, mds;
        int fr, ft;
        src_model(int'(rs_d), int'(tuse_rs), hr, fr);
        src_model(int'(rt_d), int'(tuse_rt), ht, ft);
        e_busy   = (cyc - md_e) < MD_CYCLES;
        mds      = md_use_d && e_busy && !bubble_d;
        e_stall  = !bubble_d && (hr || ht || mds);
        e_fwd_rs = fr;
        e_fwd_rt = ft;
    endtask

    task automatic check();
        @(negedge clk);
        model_eval();
        chk("stall", 32'(stall), 32'(e_stall));
        chk("fwd_rs", 32'(fwd_rs), e_fwd_rs);
        chk("fwd_rt", 32'(fwd_rt), e_fwd_rt);
        chk("md_busy", 32'(md_busy), 32'(e_busy));
    endtask

    task automatic tick();
        prod_t p;
        @(posedge clk);
        model_eval();
        cyc++;
        if (reset) begin
            prods.delete();
            md_e = -1000;
        end else begin
            while (prods.size() > 0 && (cyc - prods[0].e) >= DEPTH) void'(prods.pop_front());
            if (!bubble_d && !e_stall && wr_en_d && wr_reg_d != '0) begin
                p.e = cyc; p.rd = int'(wr_reg_d); p.tn = int'(tnew_d);
                prods.push_back(p);
            end
            if (md_start_d && !bubble_d && !e_stall) md_e = cyc;
        end
        #1;
    endtask

    task automatic cyc1();
        check();
        tick();
    endtask

    task automatic idle();
        bubble_d = 1'b0; rs_d = '0; rt_d = '0; tuse_rs = '1; tuse_rt = '1;
        wr_en_d = 1'b0; wr_reg_d = '0; tnew_d = '0; md_start_d = 1'b0; md_use_d = 1'b0;
    endtask

    task automatic producer(input logic [RAW-1:0] rd, input logic [TW-1:0] tn);
        idle();
        wr_en_d = 1'b1; wr_reg_d = rd; tnew_d = tn;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd_rs", 32'(fwd_rs), 0);
        chk("rst_fwd_rt", 32'(fwd_rt), 0);
        chk("rst_md_busy", 32'(md_busy), 0);
        tick();

        // Load-use into branch
        producer(5'd8, 2'd2); cyc1();
        idle(); rs_d = 5'd8; tuse_rs = 2'd0; tuse_rt = 2'd0;
        check(); chk("lu_stall1", 32'(stall), 1); tick();
        check(); chk("lu_stall2", 32'(stall), 1); tick();
        check(); chk("lu_go", 32'(stall), 0); chk("lu_fwd", 32'(fwd_rs), 3); tick();
        idle(); repeat (3) cyc1();

        // ALU into branch
        producer(5'd9, 2'd1); cyc1();
        idle(); rs_d = 5'd9; rt_d = 5'd9; tuse_rs = 2'd0; tuse_rt = 2'd0;
        check(); chk("alu_br_stall", 32'(stall), 1); tick();
        check(); chk("alu_br_go", 32'(stall), 0);
        chk("alu_br_fwd_rs", 32'(fwd_rs), 2); chk("alu_br_fwd_rt", 32'(fwd_rt), 2); tick();
        idle(); repeat (3) cyc1();

        // ALU into store data
        producer(5'd9, 2'd1); cyc1();
        idle(); rs_d = 5'd29; tuse_rs = 2'd1; rt_d = 5'd9; tuse_rt = 2'd2;
        check(); chk("sw_stall", 32'(stall), 0); chk("sw_fwd_rt", 32'(fwd_rt), 0); tick();
        idle(); repeat (3) cyc1();

        // $0 writes and youngest-producer priority
        producer(5'd0, 2'd2); cyc1();
        idle(); rs_d = 5'd0; tuse_rs = 2'd0;
        check(); chk("z0_stall", 32'(stall), 0); chk("z0_fwd", 32'(fwd_rs), 0); tick();
        producer(5'd8, 2'd1); cyc1();
        producer(5'd8, 2'd2); cyc1();
        idle(); rs_d = 5'd8; tuse_rs = 2'd0;
        check(); chk("pri_stall1", 32'(stall), 1); tick();
        check(); chk("pri_stall2", 32'(stall), 1); tick();
        check(); chk("pri_go", 32'(stall), 0); chk("pri_fwd", 32'(fwd_rs), 3); tick();
        idle(); repeat (3) cyc1();

        // Mult/div interlock
        idle(); md_start_d = 1'b1; md_use_d = 1'b1; cyc1();
        idle(); md_use_d = 1'b1;
        for (int i = 0; i < MD_CYCLES; i++) begin
            check(); chk("md_stall", 32'(stall), 1); chk("md_busy_on", 32'(md_busy), 1); tick();
        end
        check(); chk("md_go", 32'(stall), 0); chk("md_busy_off", 32'(md_busy), 0); tick();
        idle(); repeat (2) cyc1();

        // GPR hazard on an instruction that also starts mult/div
        producer(5'd8, 2'd2); cyc1();
        idle(); rs_d = 5'd8; tuse_rs = 2'd1; md_start_d = 1'b1; md_use_d = 1'b1;
        check(); chk("mdg_stall", 32'(stall), 1); chk("mdg_idle", 32'(md_busy), 0); tick();
        check(); chk("mdg_go", 32'(stall), 0); tick();
        idle(); check(); chk("mdg_busy", 32'(md_busy), 1); tick();
        repeat (5) cyc1();

        // Reset during a load-use stall
        producer(5'd8, 2'd2); cyc1();
        idle(); rs_d = 5'd8; tuse_rs = 2'd0;
        check(); chk("rs_mid_stall", 32'(stall), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check(); chk("rs_after_stall", 32'(stall), 0);
        chk("rs_after_fwd_rs", 32'(fwd_rs), 0); chk("rs_after_fwd_rt", 32'(fwd_rt), 0); tick();
        idle(); cyc1();

        // Bubble with a hazardous source inserts nothing
        producer(5'd8, 2'd2); cyc1();
        idle(); bubble_d = 1'b1; rs_d = 5'd8; tuse_rs = 2'd0;
        wr_en_d = 1'b1; wr_reg_d = 5'd12; tnew_d = 2'd2; md_start_d = 1'b1;
        check(); chk("bub_stall", 32'(stall), 0); chk("bub_fwd", 32'(fwd_rs), 0); tick();
        idle(); rs_d = 5'd12; tuse_rs = 2'd0;
        check(); chk("bub_no_entry", 32'(stall), 0); chk("bub_no_md", 32'(md_busy), 0); tick();
        idle(); repeat (3) cyc1();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bubble_d   = ($urandom_range(0, 7) == 0);
            rs_d       = RAW'($urandom_range(0, 3));
            rt_d       = RAW'($urandom_range(0, 3));
            tuse_rs    = TW'($urandom_range(0, 3));
            tuse_rt    = TW'($urandom_range(0, 3));
            wr_en_d    = 1'($urandom_range(0, 1));
            wr_reg_d   = RAW'($urandom_range(0, 3));
            tnew_d     = TW'($urandom_range(0, 3));
            md_start_d = ($urandom_range(0, 9) == 0);
            md_use_d   = md_start_d || ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 63) == 0);
            cyc1();
        end
        reset = 1'b0;
        idle();
        cyc1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
